decode_stage: RTL

Second pipeline stage of the 32-bit MIPS pipeline: the consumer of the instruction-fetch stage's `instruction` and `addressOut` outputs, and the producer of that stage's `pc_enable`, `PCSrc` and `adderResult` inputs. The block contains:
- the IF/ID pipeline register;
- the 32-entry register file, with write-back bypass;
- main control decode;
- load-use hazard detection, which stalls fetch;
- branch resolution in ID, which redirects and flushes fetch.

---
 rtl/decode_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, bypassed register file, control decode,
// load-use stall generation and branch resolution with fetch redirect/flush.
module decode_stage #(
  parameter int Width    = 32,
  parameter int RegCount = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] instruction,
  input  logic [Width-1:0] addressOut,
  input  logic             id_ex_memRead,
  input  logic [4:0]       id_ex_rt,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_writeReg,
  input  logic [Width-1:0] wb_writeData,
  output logic             pc_enable,
  output logic             PCSrc,
  output logic [Width-1:0] adderResult,
  output logic [Width-1:0] pcAddFour,
  output logic [Width-1:0] readData1,
  output logic [Width-1:0] readData2,
  output logic [Width-1:0] signExt,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       funct,
  output logic             regWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             aluSrc,
  output logic             regDst,
  output logic [1:0]       aluOp
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  logic [Width-1:0] r_ifid_instr;
  logic [Width-1:0] r_ifid_pc4;
  logic [Width-1:0] r_regs [RegCount];

  logic [5:0] w_opcode;
  logic       w_stall;
  logic       w_uses_rt;
  logic       w_is_beq;
  logic       w_is_bne;
  logic       w_regWrite, w_memRead, w_memWrite, w_memToReg, w_aluSrc, w_regDst;
  logic [1:0] w_aluOp;

  assign w_opcode  = r_ifid_instr[31:26];
  assign rs        = r_ifid_instr[25:21];
  assign rt        = r_ifid_instr[20:16];
  assign rd        = r_ifid_instr[15:11];
  assign funct     = r_ifid_instr[5:0];
  assign signExt   = {{(Width-16){r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign pcAddFour = r_ifid_pc4;

  // IF/ID register: stall holds, a taken branch squashes the wrong-path fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (w_stall) begin
      r_ifid_instr <= r_ifid_instr;
      r_ifid_pc4   <= r_ifid_pc4;
    end else if (PCSrc) begin
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else begin
      r_ifid_instr <= instruction;
      r_ifid_pc4   <= addressOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RegCount; i++) r_regs[i] <= '0;
    end else if (wb_regWrite && (wb_writeReg != 5'd0)) begin
      r_regs[wb_writeReg] <= wb_writeData;
    end
  end

  // Same-cycle write-back is forwarded so branch compares see the newest value
  always_comb begin
    readData1 = '0;
    if (rs != 5'd0) begin
      if (wb_regWrite && (wb_writeReg == rs)) readData1 = wb_writeData;
      else                                    readData1 = r_regs[rs];
    end
  end

  always_comb begin
    readData2 = '0;
    if (rt != 5'd0) begin
      if (wb_regWrite && (wb_writeReg == rt)) readData2 = wb_writeData;
      else                                    readData2 = r_regs[rt];
    end
  end

  always_comb begin
    w_regWrite = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_memToReg = 1'b0;
    w_aluSrc   = 1'b0;
    w_regDst   = 1'b0;
    w_aluOp    = 2'b00;
    w_uses_rt  = 1'b0;
    w_is_beq   = 1'b0;
    w_is_bne   = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_uses_rt = 1'b1;
        // the all-zero word is the pipeline NOP, not sll $0,$0,0
        if (r_ifid_instr != '0) begin
          w_regWrite = 1'b1;
          w_regDst   = 1'b1;
          w_aluOp    = 2'b10;
        end
      end
      OP_LW: begin
        w_regWrite = 1'b1;
        w_memRead  = 1'b1;
        w_memToReg = 1'b1;
        w_aluSrc   = 1'b1;
      end
      OP_SW: begin
        w_memWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_uses_rt  = 1'b1;
      end
      OP_ADDI: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
      end
      OP_BEQ: begin
        w_aluOp   = 2'b01;
        w_uses_rt = 1'b1;
        w_is_beq  = 1'b1;
      end
      OP_BNE: begin
        w_aluOp   = 2'b01;
        w_uses_rt = 1'b1;
        w_is_bne  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_stall = id_ex_memRead && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == rs) || (w_uses_rt && (id_ex_rt == rt)));

  assign pc_enable   = !w_stall;
  assign PCSrc       = !w_stall && ((w_is_beq && (readData1 == readData2)) ||
                                    (w_is_bne && (readData1 != readData2)));
  assign adderResult = r_ifid_pc4 + (signExt << 2);

  // a stalled instruction leaves a bubble in EX
  assign regWrite = w_regWrite && !w_stall;
  assign memRead  = w_memRead  && !w_stall;
  assign memWrite = w_memWrite && !w_stall;
  assign memToReg = w_memToReg && !w_stall;
  assign aluSrc   = w_aluSrc   && !w_stall;
  assign regDst   = w_regDst   && !w_stall;
  assign aluOp    = w_stall ? 2'b00 : w_aluOp;
endmodule
